// File: rtl/factor_judge.sv
// factor_judge: checks 2^e2*3^e3*5^e5 against a 3-digit BCD question, one multiply per cycle.
module factor_judge #(
  parameter int         MAXVAL   = 999,
  parameter logic [3:0] ST_INPUT = 4'b0100,
  parameter logic [3:0] ST_READY = 4'b0010
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  STATE,
  input  logic [23:0] QUESTION,
  input  logic        DEC,
  input  logic [3:0]  COUNT1_OUT,
  input  logic [3:0]  COUNT2_OUT,
  input  logic [3:0]  COUNT3_OUT,
  output logic [1:0]  RESULT,
  output logic        DONE,
  output logic        BUSY,
  output logic [12:0] PRODUCT
);
  typedef enum logic [1:0] {IDLE, LOAD, MUL, CMP} st_t;
  st_t st;
  logic [3:0] e2, e3, e5;
  logic [3:0] d2, d1, d0;
  logic [9:0] target;
  logic err, ovf, bad, none, last;
  logic [12:0] nxt;
  assign d2 = QUESTION[23:20];
  assign d1 = QUESTION[19:16];
  assign d0 = QUESTION[15:12];
  always_comb begin
    bad  = d2 > 4'd9 || d1 > 4'd9 || d0 > 4'd9 || COUNT1_OUT > 4'd9 || COUNT2_OUT > 4'd9 ||
           COUNT3_OUT > 4'd9 || QUESTION[23:12] == 12'd0;
    none = (COUNT1_OUT | COUNT2_OUT | COUNT3_OUT) == 4'd0;
    nxt  = PRODUCT * (e2 != 4'd0 ? 13'd2 : e3 != 4'd0 ? 13'd3 : 13'd5);
    last = ({2'b0, e2} + {2'b0, e3} + {2'b0, e5}) == 6'd1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      st      <= IDLE;
      RESULT  <= 2'b00;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
      PRODUCT <= 13'd1;
      err     <= 1'b0;
      ovf     <= 1'b0;
      e2      <= 4'd0;
      e3      <= 4'd0;
      e5      <= 4'd0;
      target  <= 10'd0;
    end else begin
      DONE <= 1'b0;
      case (st)
        IDLE: begin
          if (DEC && STATE == ST_INPUT) begin
            st     <= LOAD;
            RESULT <= 2'b00;
            BUSY   <= 1'b1;
            err    <= 1'b0;
            ovf    <= 1'b0;
          end else if (STATE == ST_READY) RESULT <= 2'b00;
        end
        LOAD: begin
          if (STATE != ST_INPUT) begin
            st   <= IDLE;
            BUSY <= 1'b0;
          end else begin
            e2      <= COUNT1_OUT;
            e3      <= COUNT2_OUT;
            e5      <= COUNT3_OUT;
            target  <= 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
            PRODUCT <= 13'd1;
            err     <= bad;
            st      <= (bad || none) ? CMP : MUL;
          end
        end
        MUL: begin
          if (STATE != ST_INPUT) begin
            st   <= IDLE;
            BUSY <= 1'b0;
          end else begin
            PRODUCT <= nxt;
            if (e2 != 4'd0) e2 <= e2 - 4'd1;
            else if (e3 != 4'd0) e3 <= e3 - 4'd1;
            else e5 <= e5 - 4'd1;
            // overflow ends the walk at once; PRODUCT keeps the offending value
            if (nxt > 13'(MAXVAL)) begin
              ovf <= 1'b1;
              st  <= CMP;
            end else if (last) st <= CMP;
          end
        end
        CMP: begin
          RESULT <= err ? 2'b11 : ovf ? 2'b10 : PRODUCT == {3'b0, target} ? 2'b01 : 2'b10;
          DONE   <= 1'b1;
          BUSY   <= 1'b0;
          st     <= IDLE;
        end
      endcase
    end
  end
endmodule
